rob_id_remap_ctrl: RTL and testbench

//  Sequences the row/col ID allocator between an AXI read master and the fabric.

---
 rtl/rob_pkg.sv | 41 ++++
 rtl/rob_r_slice.sv | 43 ++++
 rtl/rob_id_remap_ctrl.sv | 179 +++++++++++++++++
 tb/tb_rob_id_remap_ctrl.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// rob_pkg
//   Shared types for the AXI read-ID remapping controller.
//   - Default geometry and bus widths used by rob_id_remap_ctrl.
//   - ar_state_e : AR sequencing states.
//   - ar_beat_t  : latched AR payload (original id, address, burst length).
//   - r_beat_t   : one R beat after the original id has been restored.
//   - uid_w()    : width of the {row,col} unique ID for a given table shape.
// The struct field widths follow the ROB_* localparams below, so the top's
// width parameters must be left at (or kept equal to) these defaults.
package rob_pkg;

  localparam int ROB_ID_W       = 4;
  localparam int ROB_NUM_ROWS   = 4;
  localparam int ROB_NUM_COLS   = 4;
  localparam int ROB_ADDR_WIDTH = 32;
  localparam int ROB_DATA_WIDTH = 32;

  function automatic int uid_w(input int rows, input int cols);
    return $clog2(rows) + $clog2(cols);
  endfunction

  typedef enum logic [1:0] {
    AR_IDLE,
    AR_ALLOC,
    AR_SEND
  } ar_state_e;

  typedef struct packed {
    logic [ROB_ID_W-1:0]       id;
    logic [ROB_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
  } ar_beat_t;

  typedef struct packed {
    logic [ROB_ID_W-1:0]       id;
    logic [ROB_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
    logic                      last;
  } r_beat_t;

endpackage

// File: rtl/rob_r_slice.sv
// rob_r_slice
//   One-entry valid/ready register slice.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     in_valid/in_ready   upstream handshake, in_beat payload
//     out_valid/out_ready downstream handshake, out_beat payload
//   in_ready is high when the slot is empty or is being drained this cycle,
//   which lets beats stream at full rate when the consumer is always ready.
module rob_r_slice
  import rob_pkg::*;
#(
  parameter type beat_t = r_beat_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  output logic  in_ready,
  input  beat_t in_beat,
  output logic  out_valid,
  input  logic  out_ready,
  output beat_t out_beat
);

  logic  valid_q;
  beat_t beat_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_beat  = beat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      beat_q  <= in_beat;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rob_id_remap_ctrl.sv
// rob_id_remap_ctrl
//   Sits between an AXI read master and the fabric. Each AR gets a unique
//   {row,col} ID from an external allocator and is forwarded with that ID.
//   Returning R beats have their original ID restored through the allocator
//   lookup; the slot is released on RLAST.
//   Ports:
//     clk, rst_n                         clock, asynchronous active-low reset
//     s_ar*                              upstream AR (original ID)
//     m_ar*                              downstream AR (unique ID)
//     m_r*                               downstream R (unique ID)
//     s_r*                               upstream R (original ID)
//     alloc_req/alloc_id/alloc_gnt/alloc_uid         allocation request
//     free_req/free_uid/free_restored_id/free_ack    release and ID lookup
//     outstanding                        number of live allocated slots
//     err                                sticky protocol/allocator error
module rob_id_remap_ctrl
  import rob_pkg::*;
#(
  parameter int ID_WIDTH   = ROB_ID_W,
  parameter int NUM_ROWS   = ROB_NUM_ROWS,
  parameter int NUM_COLS   = ROB_NUM_COLS,
  parameter int ADDR_WIDTH = ROB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ROB_DATA_WIDTH,
  localparam int UID_W     = uid_w(NUM_ROWS, NUM_COLS),
  localparam int CNT_W     = $clog2(NUM_ROWS * NUM_COLS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [UID_W-1:0]      m_arid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [UID_W-1:0]      m_rid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  alloc_req,
  output logic [ID_WIDTH-1:0]   alloc_id,
  input  logic                  alloc_gnt,
  input  logic [UID_W-1:0]      alloc_uid,
  output logic                  free_req,
  output logic [UID_W-1:0]      free_uid,
  input  logic [ID_WIDTH-1:0]   free_restored_id,
  input  logic                  free_ack,
  output logic [CNT_W-1:0]      outstanding,
  output logic                  err
);

  localparam int MAX_SLOTS = NUM_ROWS * NUM_COLS;

  ar_state_e          state_q, state_d;
  ar_beat_t           ar_q;
  logic [UID_W-1:0]   uid_q;
  logic               init_q;
  logic               ar_load, uid_load;
  logic               alloc_fire, dec_ok, free_q;
  logic               slice_in_ready;
  r_beat_t            r_in, r_out;

  // init_q holds every ready/valid output low until one cycle after reset
  // release, so nothing handshakes while the allocator is still clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q  <= 1'b0;
      state_q <= AR_IDLE;
      ar_q    <= '0;
      uid_q   <= '0;
    end else begin
      init_q  <= 1'b1;
      state_q <= state_d;
      if (ar_load)  ar_q  <= '{id: s_arid, addr: s_araddr, len: s_arlen};
      if (uid_load) uid_q <= alloc_uid;
    end
  end

  // The FSM leaves AR_ALLOC on the grant edge, so the allocator sees exactly
  // one accepted request per AR.
  always_comb begin
    state_d   = state_q;
    s_arready = 1'b0;
    alloc_req = 1'b0;
    m_arvalid = 1'b0;
    ar_load   = 1'b0;
    uid_load  = 1'b0;
    case (state_q)
      AR_IDLE: begin
        s_arready = init_q;
        if (s_arvalid && init_q) begin
          ar_load = 1'b1;
          state_d = AR_ALLOC;
        end
      end
      AR_ALLOC: begin
        alloc_req = 1'b1;
        if (alloc_gnt) begin
          uid_load = 1'b1;
          state_d  = AR_SEND;
        end
      end
      AR_SEND: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = AR_IDLE;
      end
      default: state_d = AR_IDLE;
    endcase
  end

  assign alloc_id = ar_q.id;
  assign m_arid   = uid_q;
  assign m_araddr = ar_q.addr;
  assign m_arlen  = ar_q.len;

  assign free_uid = m_rid;
  assign m_rready = init_q && slice_in_ready;
  assign free_req = m_rvalid && m_rready && m_rlast;
  assign r_in     = '{id: free_restored_id, data: m_rdata, resp: m_rresp, last: m_rlast};

  rob_r_slice #(.beat_t(r_beat_t)) u_r_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (m_rvalid && init_q),
    .in_ready  (slice_in_ready),
    .in_beat   (r_in),
    .out_valid (s_rvalid),
    .out_ready (s_rready),
    .out_beat  (r_out)
  );

  assign s_rid   = r_out.id;
  assign s_rdata = r_out.data;
  assign s_rresp = r_out.resp;
  assign s_rlast = r_out.last;

  // A free at zero occupancy is an error and must not underflow; a grant
  // and a free in the same cycle cancel out.
  assign alloc_fire = alloc_req && alloc_gnt;
  assign dec_ok     = free_req && (outstanding != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (alloc_fire && !dec_ok) begin
      if (outstanding != CNT_W'(MAX_SLOTS)) outstanding <= outstanding + 1'b1;
    end else if (dec_ok && !alloc_fire) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  // free_q remembers last cycle's release so the allocator's ack can be
  // checked one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_q <= 1'b0;
      err    <= 1'b0;
    end else begin
      free_q <= free_req;
      if ((free_req && (outstanding == '0)) ||
          (free_q && !free_ack) ||
          (alloc_gnt && !alloc_req)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rob_id_remap_ctrl.sv
module tb_rob_id_remap_ctrl;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_arvalid = 0, s_arready;
  logic [3:0]  s_arid = 0;
  logic [31:0] s_araddr = 0;
  logic [7:0]  s_arlen = 0;
  logic        m_arvalid, m_arready = 0;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_rvalid = 0, m_rready;
  logic [3:0]  m_rid = 0;
  logic [31:0] m_rdata = 0;
  logic [1:0]  m_rresp = 0;
  logic        m_rlast = 0;
  logic        s_rvalid, s_rready = 0;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        alloc_req, alloc_gnt;
  logic [3:0]  alloc_id, alloc_uid;
  logic        free_req, free_ack;
  logic [3:0]  free_uid, free_restored_id;
  logic [4:0]  outstanding;
  logic        err;

  int n_vec = 0;
  int n_mis = 0;

  // Allocator environment: a 16-slot table, lowest free slot first unless
  // pref_uid names a free slot. gnt_enable/ack_enable let tests stall it.
  logic [15:0] slot_used;
  logic [3:0]  slot_id [16];
  int          pref_uid = -1;
  bit          gnt_enable = 1'b1;
  bit          ack_enable = 1'b1;

  // Reference model: which unique IDs are live and the original ID behind each.
  bit          live [16];
  logic [3:0]  exp_id [16];

  rob_id_remap_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
    .s_araddr(s_araddr), .s_arlen(s_arlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
    .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .alloc_req(alloc_req), .alloc_id(alloc_id), .alloc_gnt(alloc_gnt),
    .alloc_uid(alloc_uid),
    .free_req(free_req), .free_uid(free_uid),
    .free_restored_id(free_restored_id), .free_ack(free_ack),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  always_comb begin
    alloc_gnt = 1'b0;
    alloc_uid = 4'd0;
    if (alloc_req && gnt_enable) begin
      if (pref_uid >= 0 && pref_uid < 16 && !slot_used[4'(pref_uid)]) begin
        alloc_gnt = 1'b1;
        alloc_uid = 4'(pref_uid);
      end else begin
        for (int i = 15; i >= 0; i--) begin
          if (!slot_used[i]) begin
            alloc_gnt = 1'b1;
            alloc_uid = 4'(i);
          end
        end
      end
    end
  end

  assign free_restored_id = slot_id[free_uid];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_used <= '0;
      free_ack  <= 1'b0;
      for (int i = 0; i < 16; i++) slot_id[i] <= 4'd0;
    end else begin
      if (free_req) slot_used[free_uid] <= 1'b0;
      if (alloc_req && alloc_gnt) begin
        slot_used[alloc_uid] <= 1'b1;
        slot_id[alloc_uid]   <= alloc_id;
      end
      free_ack <= free_req && ack_enable;
    end
  end

  function automatic int live_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += live[i] ? 1 : 0;
    return n;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    s_arvalid = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0; s_rready = 0;
    pref_uid = -1; gnt_enable = 1'b1; ack_enable = 1'b1;
    for (int i = 0; i < 16; i++) live[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Full AR transaction; records the uid the DUT forwarded in the model.
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, output logic [3:0] uid);
    int cnt = 0;
    @(negedge clk);
    s_arvalid = 1'b1; s_arid = id; s_araddr = addr; s_arlen = len;
    while (!s_arready && cnt < 50) begin @(negedge clk); cnt++; end
    n_vec++;
    if (!s_arready) begin n_mis++; $display("[TB] FAIL ar_accept_timeout: s_arready got 0 want 1"); end
    @(posedge clk);
    @(negedge clk);
    s_arvalid = 1'b0;
    cnt = 0;
    while (!m_arvalid && cnt < 50) begin @(negedge clk); cnt++; end
    n_vec++;
    if (m_arvalid !== 1'b1) begin n_mis++; $display("[TB] FAIL ar_send_timeout: m_arvalid got %0b want 1", m_arvalid); end
    n_vec++;
    if (m_araddr !== addr || m_arlen !== len) begin
      n_mis++; $display("[TB] FAIL ar_payload: got %h/%h want %h/%h", m_araddr, m_arlen, addr, len);
    end
    uid = m_arid;
    live[uid] = 1'b1;
    exp_id[uid] = id;
    m_arready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_arready = 1'b0;
  endtask

  // Drives one R burst with random gaps and back-pressure; checks every
  // upstream beat against a queue of expected restored beats.
  task automatic run_burst(input logic [3:0] uid, input int nbeats, input int stall_pct,
                           output int frees, output int free_beat);
    exp_beat_t q[$];
    exp_beat_t e, got;
    int beat = 0;
    int cyc = 0;
    frees = 0; free_beat = -1;
    while ((beat < nbeats || q.size() != 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      m_rvalid = (beat < nbeats) && ($urandom_range(0, 3) != 0);
      m_rid    = uid;
      m_rdata  = $urandom;
      m_rresp  = 2'($urandom_range(0, 3));
      m_rlast  = (beat == nbeats - 1);
      s_rready = ($urandom_range(0, 99) >= stall_pct);
      #1;
      n_vec++;
      if (s_rvalid !== (q.size() != 0)) begin
        n_mis++; $display("[TB] FAIL r_svalid: got %0b want %0b", s_rvalid, q.size() != 0);
      end
      n_vec++;
      if (m_rready !== (q.size() == 0 || s_rready)) begin
        n_mis++; $display("[TB] FAIL r_mready: got %0b want %0b", m_rready, (q.size() == 0 || s_rready));
      end
      if (s_rvalid && s_rready && q.size() != 0) begin
        e = q.pop_front();
        got = '{s_rid, s_rdata, s_rresp, s_rlast};
        n_vec++;
        if (got !== e) begin n_mis++; $display("[TB] FAIL r_beat: got %h want %h", got, e); end
      end
      if (free_req) begin
        frees++;
        free_beat = beat;
        n_vec++;
        if (free_uid !== uid) begin n_mis++; $display("[TB] FAIL free_uid: got %0h want %0h", free_uid, uid); end
      end
      if (m_rvalid && m_rready) begin
        q.push_back('{exp_id[uid], m_rdata, m_rresp, m_rlast});
        beat++;
      end
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    n_vec++;
    if (cyc >= 200) begin n_mis++; $display("[TB] FAIL r_timeout: cycles got %0d want <200", cyc); end
    live[uid] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({s_arready, m_arvalid, s_rvalid, alloc_req, free_req, m_rready, err} !== 7'b0 || outstanding !== 5'd0) begin
      n_mis++; $display("[TB] FAIL reset_outputs: got %b/%0d want 0/0",
        {s_arready, m_arvalid, s_rvalid, alloc_req, free_req, m_rready, err}, outstanding);
    end
    do_reset();
    @(negedge clk);
    s_arvalid = 1'b1; s_arid = 4'($urandom); s_araddr = $urandom;
    @(posedge clk);
    @(negedge clk);
    s_arvalid = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if (m_arvalid !== 1'b1) begin n_mis++; $display("[TB] FAIL reset_setup_send: m_arvalid got %0b want 1", m_arvalid); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({m_arvalid, s_arready, alloc_req, m_rready, s_rvalid} !== 5'b0 || outstanding !== 5'd0) begin
      n_mis++; $display("[TB] FAIL reset_mid_send: got %b/%0d want 00000/0",
        {m_arvalid, s_arready, alloc_req, m_rready, s_rvalid}, outstanding);
    end
    for (int i = 0; i < 16; i++) live[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (s_arready !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_release_arready: got %0b want 0", s_arready); end
    @(negedge clk);
    #1;
    n_vec++;
    if (s_arready !== 1'b1 || m_arvalid !== 1'b0) begin
      n_mis++; $display("[TB] FAIL reset_arready_rise: got %0b/%0b want 1/0", s_arready, m_arvalid);
    end
  endtask

  task automatic test_single_ar();
    logic [7:0] len = 8'($urandom);
    do_reset();
    @(negedge clk);
    s_arvalid = 1'b1; s_arid = 4'd3; s_araddr = 32'h100; s_arlen = len;
    #1;
    n_vec++;
    if (s_arready !== 1'b1) begin n_mis++; $display("[TB] FAIL single_arready: got %0b want 1", s_arready); end
    @(posedge clk);
    @(negedge clk);
    s_arvalid = 1'b0;
    #1;
    n_vec++;
    if (alloc_req !== 1'b1 || alloc_id !== 4'd3 || m_arvalid !== 1'b0) begin
      n_mis++; $display("[TB] FAIL single_alloc: got req=%0b id=%0h mv=%0b want 1/3/0", alloc_req, alloc_id, m_arvalid);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (m_arvalid !== 1'b1 || m_arid !== 4'h0 || m_araddr !== 32'h100 || m_arlen !== len || alloc_req !== 1'b0) begin
      n_mis++; $display("[TB] FAIL single_send: got v=%0b id=%0h a=%h l=%h r=%0b want 1/0/100/%h/0",
        m_arvalid, m_arid, m_araddr, m_arlen, alloc_req, len);
    end
    live[0] = 1'b1; exp_id[0] = 4'd3;
    n_vec++;
    if (outstanding !== 5'(live_count())) begin
      n_mis++; $display("[TB] FAIL single_outstanding: got %0d want %0d", outstanding, live_count());
    end
    @(negedge clk);
    n_vec++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h100) begin
      n_mis++; $display("[TB] FAIL single_hold: got %0b/%h want 1/100", m_arvalid, m_araddr);
    end
    m_arready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_arready = 1'b0;
    #1;
    n_vec++;
    if (m_arvalid !== 1'b0 || s_arready !== 1'b1) begin
      n_mis++; $display("[TB] FAIL single_done: got %0b/%0b want 0/1", m_arvalid, s_arready);
    end
  endtask

  task automatic test_table_full();
    logic [3:0] uid, k;
    int frees, fb;
    do_reset();
    for (int i = 0; i < 16; i++) send_ar(4'd5, $urandom, 8'($urandom), uid);
    n_vec++;
    if (outstanding !== 5'd16) begin n_mis++; $display("[TB] FAIL full_count: got %0d want 16", outstanding); end
    @(negedge clk);
    s_arvalid = 1'b1; s_arid = 4'd5; s_araddr = $urandom;
    @(posedge clk);
    @(negedge clk);
    s_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (alloc_req !== 1'b1 || s_arready !== 1'b0 || m_arvalid !== 1'b0) begin
        n_mis++; $display("[TB] FAIL full_hold: got req=%0b ar=%0b mv=%0b want 1/0/0", alloc_req, s_arready, m_arvalid);
      end
      @(negedge clk);
    end
    k = 4'($urandom_range(0, 15));
    run_burst(k, 1, 0, frees, fb);
    n_vec++;
    if (m_arvalid !== 1'b0 || outstanding !== 5'd15) begin
      n_mis++; $display("[TB] FAIL full_after_free: got mv=%0b cnt=%0d want 0/15", m_arvalid, outstanding);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (m_arvalid !== 1'b1 || m_arid !== k || outstanding !== 5'd16) begin
      n_mis++; $display("[TB] FAIL full_regrant: got mv=%0b id=%0h cnt=%0d want 1/%0h/16", m_arvalid, m_arid, outstanding, k);
    end
    live[k] = 1'b1; exp_id[k] = 4'd5;
    m_arready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_arready = 1'b0;
  endtask

  task automatic test_r_burst();
    logic [3:0] uid;
    int frees, fb;
    do_reset();
    pref_uid = 5;
    send_ar(4'd2, $urandom, 8'd3, uid);
    pref_uid = -1;
    n_vec++;
    if (uid !== 4'h5 || outstanding !== 5'd1) begin
      n_mis++; $display("[TB] FAIL burst_setup: got uid=%0h cnt=%0d want 5/1", uid, outstanding);
    end
    run_burst(4'h5, 4, 30, frees, fb);
    n_vec++;
    if (frees !== 1 || fb !== 3) begin
      n_mis++; $display("[TB] FAIL burst_free: got frees=%0d beat=%0d want 1/3", frees, fb);
    end
    @(negedge clk);
    n_vec++;
    if (outstanding !== 5'd0 || err !== 1'b0) begin
      n_mis++; $display("[TB] FAIL burst_count: got cnt=%0d err=%0b want 0/0", outstanding, err);
    end
  endtask

  task automatic test_same_cycle();
    logic [3:0] uid;
    do_reset();
    for (int i = 0; i < 7; i++) send_ar(4'($urandom), $urandom, 8'($urandom), uid);
    gnt_enable = 1'b0;
    @(negedge clk);
    s_arvalid = 1'b1; s_arid = 4'd9; s_araddr = $urandom;
    @(posedge clk);
    @(negedge clk);
    s_arvalid = 1'b0;
    #1;
    n_vec++;
    if (alloc_req !== 1'b1 || outstanding !== 5'd7) begin
      n_mis++; $display("[TB] FAIL same_setup: got req=%0b cnt=%0d want 1/7", alloc_req, outstanding);
    end
    gnt_enable = 1'b1;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 4'd2; m_rdata = $urandom; s_rready = 1'b1;
    #1;
    n_vec++;
    if (free_req !== 1'b1 || alloc_gnt !== 1'b1) begin
      n_mis++; $display("[TB] FAIL same_both: got free=%0b gnt=%0b want 1/1", free_req, alloc_gnt);
    end
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    n_vec++;
    if (outstanding !== 5'd7 || err !== 1'b0 || m_arid !== 4'd7 || s_rid !== exp_id[2]) begin
      n_mis++; $display("[TB] FAIL same_result: got cnt=%0d err=%0b uid=%0h rid=%0h want 7/0/7/%0h",
        outstanding, err, m_arid, s_rid, exp_id[2]);
    end
    live[2] = 1'b0; live[7] = 1'b1; exp_id[7] = 4'd9;
    m_arready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_arready = 1'b0;
    n_vec++;
    if (err !== 1'b0) begin n_mis++; $display("[TB] FAIL same_ack: err got %0b want 0", err); end
  endtask

  task automatic test_underflow_err();
    logic [3:0] uid;
    do_reset();
    @(negedge clk);
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 4'($urandom); s_rready = 1'b1;
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    n_vec++;
    if (err !== 1'b1 || outstanding !== 5'd0) begin
      n_mis++; $display("[TB] FAIL underflow: got err=%0b cnt=%0d want 1/0", err, outstanding);
    end
    repeat (4) @(negedge clk);
    send_ar(4'($urandom), $urandom, 8'd0, uid);
    n_vec++;
    if (err !== 1'b1 || outstanding !== 5'd1) begin
      n_mis++; $display("[TB] FAIL underflow_sticky: got err=%0b cnt=%0d want 1/1", err, outstanding);
    end
    do_reset();
    n_vec++;
    if (err !== 1'b0) begin n_mis++; $display("[TB] FAIL underflow_clear: err got %0b want 0", err); end
  endtask

  task automatic test_missing_ack();
    logic [3:0] uid;
    do_reset();
    send_ar(4'($urandom), $urandom, 8'd0, uid);
    ack_enable = 1'b0;
    @(negedge clk);
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = uid; s_rready = 1'b1;
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0;
    live[uid] = 1'b0;
    #1;
    n_vec++;
    if (err !== 1'b0 || outstanding !== 5'd0) begin
      n_mis++; $display("[TB] FAIL noack_early: got err=%0b cnt=%0d want 0/0", err, outstanding);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (err !== 1'b1) begin n_mis++; $display("[TB] FAIL noack_err: got %0b want 1", err); end
    ack_enable = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] uid;
    int frees, fb, start;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      if (live_count() < 16 && (live_count() == 0 || $urandom_range(0, 1) == 0)) begin
        send_ar(4'($urandom), $urandom, 8'($urandom), uid);
      end else begin
        start = $urandom_range(0, 15);
        uid = 4'(start);
        for (int j = 0; j < 16; j++) if (!live[uid]) uid = uid + 4'd1;
        run_burst(uid, $urandom_range(1, 4), 25, frees, fb);
        n_vec++;
        if (frees !== 1) begin n_mis++; $display("[TB] FAIL b2b_frees: got %0d want 1", frees); end
      end
      @(negedge clk);
      n_vec++;
      if (outstanding !== 5'(live_count()) || err !== 1'b0) begin
        n_mis++; $display("[TB] FAIL b2b_count: got cnt=%0d err=%0b want %0d/0", outstanding, err, live_count());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_ar();
    test_table_full();
    test_r_burst();
    test_same_cycle();
    test_underflow_err();
    test_missing_ack();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
